// File: rtl/mem_bank_responder.sv
// mem_bank_responder
// Memory-side responder for the controller's memory-bank port. Holds a
// 2^ADDR_W x DATA_W synchronous RAM serving instruction fetches (pc_addr)
// and data accesses (mb_addr). Level-held controller strobes are
// edge-detected so every request executes exactly once, after WAIT_CYCLES
// wait states, with a one-cycle mb_ack pulse and a mb_busy flag.
//
// Optional feature macro: MB_WRITE_PROTECT_EN
//   defined   : writes whose latched address is below PROT_LIMIT are rejected
//               (no store, mb_err pulses with mb_ack).
//   undefined : every address is writable; mb_err only flags a request that
//               raised mb_read and mb_write together.

module mem_bank_responder #(
   parameter int                DATA_W      = 16,
   parameter int                ADDR_W      = 8,
   parameter int                WAIT_CYCLES = 2,
   parameter logic [ADDR_W-1:0] PROT_LIMIT  = ADDR_W'(8'h40)
) (
   input  logic              CLK100MHZ,
   input  logic              RST,
   input  logic              mb_sel,
   input  logic [ADDR_W-1:0] pc_addr,
   input  logic [ADDR_W-1:0] mb_addr,
   input  logic              mb_read,
   input  logic              mb_write,
   input  logic [DATA_W-1:0] mb_wdata,
   output logic [DATA_W-1:0] mb_rdata,
   output logic              mb_ack,
   output logic              mb_busy,
   output logic              mb_err
);

   localparam int DEPTH = 1 << ADDR_W;

`ifdef MB_WRITE_PROTECT_EN
   localparam bit PROT_EN = 1'b1;
`else
   localparam bit PROT_EN = 1'b0;
`endif

   // Sequencer states
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_WAIT   = 3'd1;
   localparam logic [2:0] S_ACCESS = 3'd2;
   localparam logic [2:0] S_RESP   = 3'd3;
   localparam logic [2:0] S_HOLD   = 3'd4;

   logic [2:0]        state;
   logic [3:0]        wait_cnt;
   logic              strobe_q;     // previous value of (mb_read | mb_write)
   logic              armed;        // strobes seen low since reset
   logic              req_read;     // latched, already qualified by reject
   logic              req_write;
   logic              req_reject;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;

   // Contents start at zero and survive RST.
   logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

   logic              strobe_any;
   logic              req_edge;
   logic [ADDR_W-1:0] sel_addr;
   logic              reject_now;

   assign strobe_any = mb_read | mb_write;
   assign sel_addr   = mb_sel ? mb_addr : pc_addr;

   // A strobe still high when reset releases must drop before it counts
   // again, which the edge register alone (reset to 0) cannot guarantee.
   assign req_edge   = strobe_any & ~strobe_q & armed;

   // Simultaneous read/write is always rejected; protected stores only
   // when the protection build is selected.
   assign reject_now = (mb_read & mb_write)
                     | (PROT_EN & mb_write & ~mb_read & (sel_addr < PROT_LIMIT));

   // Request sequencer: edge capture, wait states, access, ack and hold.
   // NOTE: every register here is assigned with <= so that all of them
   // update from the same pre-edge values, exactly like the flops they model.
   always_ff @(posedge CLK100MHZ) begin
      if (RST) begin
         state      <= S_IDLE;
         wait_cnt   <= '0;
         strobe_q   <= 1'b0;
         armed      <= 1'b0;
         req_read   <= 1'b0;
         req_write  <= 1'b0;
         req_reject <= 1'b0;
         req_addr   <= '0;
         req_wdata  <= '0;
         mb_rdata   <= '0;
         mb_ack     <= 1'b0;
         mb_busy    <= 1'b0;
         mb_err     <= 1'b0;
      end else begin
         strobe_q <= strobe_any;
         if (!strobe_any) begin
            armed <= 1'b1;
         end
         mb_ack <= 1'b0;
         mb_err <= 1'b0;

         case (state)
            S_IDLE: begin
               if (req_edge) begin
                  req_read   <= mb_read & ~reject_now;
                  req_write  <= mb_write & ~reject_now;
                  req_reject <= reject_now;
                  req_addr   <= sel_addr;
                  req_wdata  <= mb_wdata;
                  mb_busy    <= 1'b1;
                  if (WAIT_CYCLES == 0) begin
                     state <= S_ACCESS;
                  end else begin
                     wait_cnt <= 4'(WAIT_CYCLES);
                     state    <= S_WAIT;
                  end
               end
            end

            S_WAIT: begin
               if (wait_cnt <= 4'd1) begin
                  state <= S_ACCESS;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end

            S_ACCESS: begin
               if (req_read) begin
                  mb_rdata <= mem[req_addr];
               end
               state <= S_RESP;
            end

            S_RESP: begin
               mb_ack <= 1'b1;
               mb_err <= req_reject;
               state  <= S_HOLD;
            end

            S_HOLD: begin
               if (!strobe_any) begin
                  mb_busy <= 1'b0;
                  state   <= S_IDLE;
               end
            end

            default: begin
               mb_busy <= 1'b0;
               state   <= S_IDLE;
            end
         endcase
      end
   end

   // RAM write port: commits at the end of the ACCESS cycle, independent
   // of RST so a store reaching ACCESS is never lost.
   // NOTE: the array has no reset branch; clearing it would turn the RAM
   // into thousands of resettable flops instead of a block memory.
   always_ff @(posedge CLK100MHZ) begin
      if (state == S_ACCESS && req_write) begin
         mem[req_addr] <= req_wdata;
      end
   end

endmodule

// File: tb/tb_mem_bank_responder.sv
// Directed bench for mem_bank_responder. Two instances share all inputs:
// u_dut with WAIT_CYCLES=2 and u_dut0 with WAIT_CYCLES=0, so both latency
// paths are checked on every transaction.

module tb_mem_bank_responder;

`ifdef MB_WRITE_PROTECT_EN
   localparam bit PROT = 1'b1;
`else
   localparam bit PROT = 1'b0;
`endif

   localparam logic [15:0] FETCH_WORD = PROT ? 16'h0000 : 16'h8305;
   localparam logic [15:0] LOW_WORD   = PROT ? 16'h0000 : 16'h1234;

   logic        clk = 1'b0;
   logic        rst;
   logic        mb_sel;
   logic [7:0]  pc_addr;
   logic [7:0]  mb_addr;
   logic        mb_read;
   logic        mb_write;
   logic [15:0] mb_wdata;

   logic [15:0] rdata, rdata0;
   logic        ack, ack0, busy, busy0, err, err0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_bank_responder #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(2), .PROT_LIMIT(8'h40)) u_dut (
      .CLK100MHZ(clk), .RST(rst), .mb_sel(mb_sel), .pc_addr(pc_addr), .mb_addr(mb_addr),
      .mb_read(mb_read), .mb_write(mb_write), .mb_wdata(mb_wdata),
      .mb_rdata(rdata), .mb_ack(ack), .mb_busy(busy), .mb_err(err)
   );

   mem_bank_responder #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(0), .PROT_LIMIT(8'h40)) u_dut0 (
      .CLK100MHZ(clk), .RST(rst), .mb_sel(mb_sel), .pc_addr(pc_addr), .mb_addr(mb_addr),
      .mb_read(mb_read), .mb_write(mb_write), .mb_wdata(mb_wdata),
      .mb_rdata(rdata0), .mb_ack(ack0), .mb_busy(busy0), .mb_err(err0)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and sample 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full transaction with the strobe raised just before edge N, held
   // through ack plus `hold` extra cycles, then dropped.
   task automatic run_req(input string tag, input logic rd, input logic wr, input logic sel,
                          input logic [7:0] a, input logic [7:0] pc, input logic [15:0] wd,
                          input int hold, input logic exp_err,
                          input logic [15:0] exp_rd, input logic [15:0] exp_rd0);
      mb_sel = sel; mb_addr = a; pc_addr = pc; mb_wdata = wd;
      mb_read = rd; mb_write = wr;
      tick();                                   // cycle N
      tick();                                   // cycle N+1
      check({tag, "/busy@N+1"}, busy, 1'b1);
      check({tag, "/ack@N+1"}, ack, 1'b0);
      tick();                                   // cycle N+2
      check({tag, "/ack0@N+2"}, ack0, 1'b1);
      check({tag, "/err0@N+2"}, err0, exp_err);
      check({tag, "/rdata0@N+2"}, rdata0, exp_rd0);
      check({tag, "/ack@N+2"}, ack, 1'b0);
      tick();                                   // cycle N+3
      check({tag, "/ack@N+3"}, ack, 1'b0);
      check({tag, "/ack0@N+3"}, ack0, 1'b0);
      tick();                                   // cycle N+4
      check({tag, "/ack@N+4"}, ack, 1'b1);
      check({tag, "/err@N+4"}, err, exp_err);
      check({tag, "/rdata@N+4"}, rdata, exp_rd);
      for (int i = 0; i < hold; i++) begin
         tick();
         check({tag, "/ack_held"}, ack, 1'b0);
         check({tag, "/busy_held"}, busy, 1'b1);
      end
      mb_read = 1'b0; mb_write = 1'b0;
      tick();
      check({tag, "/busy_fall"}, busy, 1'b0);
      check({tag, "/busy0_fall"}, busy0, 1'b0);
      tick();
   endtask

   initial begin
      rst = 1'b1; mb_sel = 1'b0; pc_addr = '0; mb_addr = '0;
      mb_read = 1'b0; mb_write = 1'b0; mb_wdata = '0;
      tick();
      tick();
      check("reset/rdata", rdata, 16'h0);
      check("reset/ack", ack, 1'b0);
      check("reset/busy", busy, 1'b0);
      check("reset/err", err, 1'b0);
      check("reset/busy0", busy0, 1'b0);
      rst = 1'b0;
      tick();
      check("idle/busy", busy, 1'b0);

      // Preload the fetch word at 8'h00 through the data path.
      run_req("preload", 1'b0, 1'b1, 1'b1, 8'h00, 8'h55, 16'h8305, 1, PROT, 16'h0, 16'h0);

      // Fetch from pc_addr=0 while mb_addr points at an empty word.
      run_req("fetch", 1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 16'h0, 3, 1'b0, FETCH_WORD, FETCH_WORD);

      // Store held for 20 cycles: one ack, no retrigger; rdata unchanged.
      run_req("store", 1'b0, 1'b1, 1'b1, 8'h80, 8'h00, 16'hBEEF, 20, 1'b0, FETCH_WORD, FETCH_WORD);
      run_req("load80", 1'b1, 1'b0, 1'b1, 8'h80, 8'h00, 16'h0, 1, 1'b0, 16'hBEEF, 16'hBEEF);

      // Conflict at 8'h90: seed it, then leave rdata at BEEF before conflicting.
      run_req("seed90", 1'b0, 1'b1, 1'b1, 8'h90, 8'h00, 16'h5A5A, 1, 1'b0, 16'hBEEF, 16'hBEEF);
      run_req("read90", 1'b1, 1'b0, 1'b1, 8'h90, 8'h00, 16'h0, 1, 1'b0, 16'h5A5A, 16'h5A5A);
      run_req("read80", 1'b1, 1'b0, 1'b1, 8'h80, 8'h00, 16'h0, 1, 1'b0, 16'hBEEF, 16'hBEEF);
      run_req("conflict", 1'b1, 1'b1, 1'b1, 8'h90, 8'h00, 16'hFFFF, 2, 1'b1, 16'hBEEF, 16'hBEEF);
      run_req("reread90", 1'b1, 1'b0, 1'b1, 8'h90, 8'h00, 16'h0, 1, 1'b0, 16'h5A5A, 16'h5A5A);

      // Strobe released before ack: request completes, HOLD passes straight to IDLE.
      mb_sel = 1'b1; mb_addr = 8'h80; mb_read = 1'b1;
      tick();                                   // N
      tick();                                   // N+1
      mb_read = 1'b0;
      tick();                                   // N+2
      tick();                                   // N+3
      check("early/ack@N+3", ack, 1'b0);
      tick();                                   // N+4
      check("early/ack@N+4", ack, 1'b1);
      check("early/rdata", rdata, 16'hBEEF);
      check("early/busy@N+4", busy, 1'b1);
      tick();                                   // N+5
      check("early/busy@N+5", busy, 1'b0);
      check("early/ack@N+5", ack, 1'b0);
      tick();

      // Reset during the first WAIT cycle of a write to 8'h91. The zero-wait
      // instance is already at its ACCESS edge, so its store commits.
      mb_sel = 1'b1; mb_addr = 8'h91; mb_wdata = 16'h7777; mb_write = 1'b1;
      tick();                                   // N
      rst = 1'b1;
      tick();                                   // N+1, reset sampled
      check("rst/rdata", rdata, 16'h0);
      check("rst/ack", ack, 1'b0);
      check("rst/busy", busy, 1'b0);
      check("rst/err", err, 1'b0);
      check("rst/rdata0", rdata0, 16'h0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rst/no_retrigger", busy, 1'b0);
         check("rst/no_retrigger0", busy0, 1'b0);
      end
      mb_write = 1'b0;
      tick();
      run_req("read91", 1'b1, 1'b0, 1'b1, 8'h91, 8'h00, 16'h0, 1, 1'b0, 16'h0000, 16'h7777);

      // Write-protection boundary around 8'h40.
      run_req("wr10", 1'b0, 1'b1, 1'b1, 8'h10, 8'h00, 16'h1234, 1, PROT, 16'h0000, 16'h7777);
      run_req("rd10", 1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 16'h0, 1, 1'b0, LOW_WORD, LOW_WORD);
      run_req("wr40", 1'b0, 1'b1, 1'b1, 8'h40, 8'h00, 16'h4321, 1, 1'b0, LOW_WORD, LOW_WORD);
      run_req("rd40", 1'b1, 1'b0, 1'b1, 8'h40, 8'h00, 16'h0, 1, 1'b0, 16'h4321, 16'h4321);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
